// File: rtl/pattern_vg_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// pattern_vg_ctrl_if: config-side / pattern-stage bundle for pattern_vg_ctrl.   Rev 1.0
// ------------------------------------------------------------------------------------------
interface pattern_vg_ctrl_if #(
    parameter int B               = 8,
    parameter int X_BITS          = 13,
    parameter int FRACTIONAL_BITS = 12
);
    logic                          vn_in;
    logic [X_BITS-1:0]             total_active_pix;
    logic [7:0]                    cfg_pattern;
    logic                          cfg_auto;
    logic [7:0]                    pattern;
    logic [B+FRACTIONAL_BITS-1:0]  ramp_step;
    logic                          busy;
    logic                          frame_start;

    modport master (
        output vn_in, total_active_pix, cfg_pattern, cfg_auto,
        input  pattern, ramp_step, busy, frame_start
    );

    modport slave (
        input  vn_in, total_active_pix, cfg_pattern, cfg_auto,
        output pattern, ramp_step, busy, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/pattern_vg_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// pattern_vg_ctrl: frame-synchronous ramp-step divider and pattern auto-cycler.   Rev 1.0
// ------------------------------------------------------------------------------------------
module pattern_vg_ctrl #(
    parameter int B                  = 8,
    parameter int X_BITS             = 13,
    parameter int FRACTIONAL_BITS    = 12,
    parameter int NUM_PATTERNS       = 5,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int VS_POL             = 1
) (
    input  wire logic          clk_in,
    input  wire logic          reset,
    pattern_vg_ctrl_if.slave   bus
);
    localparam int c_step_w = B + FRACTIONAL_BITS;
    localparam int c_cnt_w  = $clog2(c_step_w + 1);
    localparam int c_fcnt_w = $clog2(FRAMES_PER_PATTERN + 1);
    localparam int c_idx_w  = $clog2(NUM_PATTERNS + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(c_step_w);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FRAMES_PER_PATTERN - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_PATTERNS - 1);
    localparam logic                c_vs_act    = 1'(VS_POL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [X_BITS-1:0]     r_latched_pix;
    logic [X_BITS-1:0]     r_rem;
    logic [c_step_w:0]     r_num;
    logic [c_step_w:0]     r_quot;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_step_w-1:0]   r_shadow;
    logic [c_step_w-1:0]   r_ramp_step;
    logic                  r_pending;
    logic                  r_vs_prev;
    logic                  r_frame_start;
    logic [7:0]            r_pattern;
    logic [c_fcnt_w-1:0]   r_frame_cnt;
    logic [c_idx_w-1:0]    r_idx;

    logic                  w_boundary;
    logic                  w_commit;
    logic [X_BITS:0]       w_trial;
    logic                  w_fits;
    logic [X_BITS-1:0]     w_diff;
    logic [c_idx_w-1:0]    w_idx_next;

    assign w_boundary = (bus.vn_in == c_vs_act) && (r_vs_prev != c_vs_act);
    assign w_commit   = w_boundary && r_pending && (r_state == ST_IDLE);

    // Restoring step: remainder stays below the divisor, so the low X_BITS of the difference suffice.
    assign w_trial    = {r_rem, r_num[c_step_w]};
    assign w_fits     = (w_trial >= {1'b0, r_latched_pix});
    assign w_diff     = w_trial[X_BITS-1:0] - r_latched_pix;
    assign w_idx_next = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;

    assign bus.pattern     = r_pattern;
    assign bus.ramp_step   = r_ramp_step;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = (r_state != ST_IDLE) || r_pending;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_latched_pix <= '0;
            r_rem         <= '0;
            r_num         <= '0;
            r_quot        <= '0;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_ramp_step   <= '0;
            r_pending     <= 1'b0;
            r_vs_prev     <= c_vs_act;
            r_frame_start <= 1'b0;
            r_pattern     <= '0;
            r_frame_cnt   <= '0;
            r_idx         <= '0;
        end else begin
            r_vs_prev     <= bus.vn_in;
            r_frame_start <= w_boundary;

            if (w_boundary) begin
                if (bus.cfg_auto) begin
                    if (r_frame_cnt == c_fcnt_last) begin
                        r_frame_cnt <= '0;
                        r_idx       <= w_idx_next;
                        r_pattern   <= 8'(w_idx_next);
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_pattern   <= 8'(r_idx);
                    end
                end else begin
                    r_pattern <= bus.cfg_pattern;
                end
            end

            if (w_commit) begin
                r_ramp_step <= r_shadow;
                r_pending   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.total_active_pix != r_latched_pix) begin
                        r_latched_pix <= bus.total_active_pix;
                        r_rem         <= '0;
                        r_num         <= {1'b1, {c_step_w{1'b0}}};
                        r_quot        <= '0;
                        r_cnt         <= '0;
                        r_state       <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_rem  <= w_fits ? w_diff : w_trial[X_BITS-1:0];
                    r_quot <= {r_quot[c_step_w-1:0], w_fits};
                    r_num  <= r_num << 1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_shadow  <= ((r_latched_pix == '0) || r_quot[c_step_w]) ? '1
                                                                              : r_quot[c_step_w-1:0];
                    r_pending <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pattern_vg_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_pattern_vg_ctrl: directed self-checking bench for pattern_vg_ctrl.   Rev 1.0
// ------------------------------------------------------------------------------------------
module tb_pattern_vg_ctrl;
    localparam int B      = 8;
    localparam int X_BITS = 13;
    localparam int FB     = 12;
    localparam int NP     = 5;
    localparam int FPP    = 2;
    localparam int VS_POL = 1;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    pattern_vg_ctrl_if #(.B(B), .X_BITS(X_BITS), .FRACTIONAL_BITS(FB)) bus ();

    pattern_vg_ctrl #(
        .B(B), .X_BITS(X_BITS), .FRACTIONAL_BITS(FB),
        .NUM_PATTERNS(NP), .FRAMES_PER_PATTERN(FPP), .VS_POL(VS_POL)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic boundary();
        bus.vn_in = 1'b1;
        tick(1);
    endtask

    task automatic end_frame();
        bus.vn_in = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.vn_in = 1'b0;
        bus.total_active_pix = 13'd1920;
        bus.cfg_pattern = 8'h03;
        bus.cfg_auto = 1'b0;
        tick(3);
        n_cmp++; if (bus.pattern !== 8'h00) begin n_bad++; $display("FAIL reset_pattern got %h want 00", bus.pattern); end
        n_cmp++; if (bus.ramp_step !== 20'h0) begin n_bad++; $display("FAIL reset_ramp got %h want 00000", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
        reset = 1'b1;
        tick(1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL release_busy got %b want 1", bus.busy); end
    endtask

    task automatic test_first_step();
        tick(23);
        n_cmp++; if (bus.ramp_step !== 20'h0) begin n_bad++; $display("FAIL first_pre_ramp got %h want 00000", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL first_pending_busy got %b want 1", bus.busy); end
        n_cmp++; if (bus.pattern !== 8'h00) begin n_bad++; $display("FAIL first_pre_pattern got %h want 00", bus.pattern); end
        boundary();
        n_cmp++; if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL first_fs got %b want 1", bus.frame_start); end
        n_cmp++; if (bus.ramp_step !== 20'h00222) begin n_bad++; $display("FAIL first_ramp got %h want 00222", bus.ramp_step); end
        n_cmp++; if (bus.pattern !== 8'h03) begin n_bad++; $display("FAIL first_pattern got %h want 03", bus.pattern); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL first_busy_clear got %b want 0", bus.busy); end
        end_frame();
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL first_fs_low got %b want 0", bus.frame_start); end
    endtask

    task automatic test_step_1280();
        bus.total_active_pix = 13'd1280;
        tick(23);
        n_cmp++; if (bus.ramp_step !== 20'h00222) begin n_bad++; $display("FAIL s1280_hold got %h want 00222", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL s1280_busy got %b want 1", bus.busy); end
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'h00333) begin n_bad++; $display("FAIL s1280_ramp got %h want 00333", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL s1280_busy_clear got %b want 0", bus.busy); end
        end_frame();
    endtask

    task automatic test_saturate();
        bus.total_active_pix = 13'd1;
        tick(24);
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'hFFFFF) begin n_bad++; $display("FAIL sat_one got %h want fffff", bus.ramp_step); end
        end_frame();
        bus.total_active_pix = 13'd1920;
        tick(24);
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'h00222) begin n_bad++; $display("FAIL sat_back got %h want 00222", bus.ramp_step); end
        end_frame();
        bus.total_active_pix = 13'd0;
        tick(24);
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'hFFFFF) begin n_bad++; $display("FAIL sat_zero got %h want fffff", bus.ramp_step); end
        end_frame();
    endtask

    task automatic test_done_at_boundary();
        bus.total_active_pix = 13'd1280;
        tick(22);
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'hFFFFF) begin n_bad++; $display("FAIL done_bnd_hold got %h want fffff", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL done_bnd_busy got %b want 1", bus.busy); end
        n_cmp++; if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL done_bnd_fs got %b want 1", bus.frame_start); end
        end_frame();
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'h00333) begin n_bad++; $display("FAIL done_bnd_next got %h want 00333", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_bnd_clear got %b want 0", bus.busy); end
        end_frame();
    endtask

    task automatic test_auto();
        logic [7:0] seq [10];
        seq = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd0};
        bus.cfg_auto = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.cfg_auto = 1'b0;
                bus.cfg_pattern = 8'hA5;
                boundary();
                n_cmp++; if (bus.pattern !== 8'hA5) begin n_bad++; $display("FAIL auto_manual_gap got %h want a5", bus.pattern); end
                end_frame();
                bus.cfg_auto = 1'b1;
            end
            bus.cfg_pattern = 8'(8'h40 + i * 7);
            tick(2);
            boundary();
            n_cmp++; if (bus.pattern !== seq[i]) begin n_bad++; $display("FAIL auto_seq[%0d] got %h want %h", i, bus.pattern, seq[i]); end
            n_cmp++; if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL auto_fs[%0d] got %b want 1", i, bus.frame_start); end
            end_frame();
            n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL auto_fs_low[%0d] got %b want 0", i, bus.frame_start); end
        end
        bus.cfg_auto = 1'b0;
        bus.cfg_pattern = 8'h11;
        tick(3);
        n_cmp++; if (bus.pattern !== 8'h00) begin n_bad++; $display("FAIL midframe_cfg got %h want 00", bus.pattern); end
    endtask

    task automatic test_change_mid_div();
        bus.total_active_pix = 13'd1920;
        tick(11);
        bus.total_active_pix = 13'd800;
        tick(20);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL chg_busy_a got %b want 1", bus.busy); end
        n_cmp++; if (bus.ramp_step !== 20'h00333) begin n_bad++; $display("FAIL chg_hold got %h want 00333", bus.ramp_step); end
        tick(20);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL chg_busy_b got %b want 1", bus.busy); end
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'h0051E) begin n_bad++; $display("FAIL chg_ramp got %h want 0051e", bus.ramp_step); end
        n_cmp++; if (bus.pattern !== 8'h11) begin n_bad++; $display("FAIL chg_pattern got %h want 11", bus.pattern); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL chg_busy_clear got %b want 0", bus.busy); end
        end_frame();
    endtask

    task automatic test_reset_mid_div();
        bus.total_active_pix = 13'd1920;
        bus.cfg_pattern = 8'h22;
        tick(10);
        reset = 1'b0;
        tick(1);
        n_cmp++; if (bus.pattern !== 8'h00) begin n_bad++; $display("FAIL rmid_pattern got %h want 00", bus.pattern); end
        n_cmp++; if (bus.ramp_step !== 20'h0) begin n_bad++; $display("FAIL rmid_ramp got %h want 00000", bus.ramp_step); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL rmid_fs got %b want 0", bus.frame_start); end
        reset = 1'b1;
        tick(1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rmid_rebusy got %b want 1", bus.busy); end
        tick(23);
        boundary();
        n_cmp++; if (bus.ramp_step !== 20'h00222) begin n_bad++; $display("FAIL rmid_ramp_final got %h want 00222", bus.ramp_step); end
        n_cmp++; if (bus.pattern !== 8'h22) begin n_bad++; $display("FAIL rmid_pattern_final got %h want 22", bus.pattern); end
        end_frame();
    endtask

    initial begin
        bus.vn_in = 1'b0;
        bus.total_active_pix = '0;
        bus.cfg_pattern = '0;
        bus.cfg_auto = 1'b0;
        test_reset();
        test_first_step();
        test_step_1280();
        test_saturate();
        test_done_at_boundary();
        test_auto();
        test_change_mid_div();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pattern_vg_ctrl.md
Name: pattern_vg_ctrl

Overview:
Configuration sequencer for the video test-pattern stage.
- Computes the fixed-point horizontal ramp increment from the active line width with an iterative divider.
- Holds `pattern` and `ramp_step` in shadow registers and commits them to the pattern stage only at frame boundaries, so a frame is never drawn with mixed settings.
- Optionally auto-cycles through the patterns every N frames.
- Sits between the register/config interface and the pattern generator, sharing its clock.

Parameters:
- B, 8, bits per colour channel
- X_BITS, 13, width of pixel count
- FRACTIONAL_BITS, 12, fractional bits of ramp_step
- NUM_PATTERNS, 5, auto-cycle pattern count; codes 0..NUM_PATTERNS-1
- FRAMES_PER_PATTERN, 120, frames each pattern is shown in auto mode (>=1)
- VS_POL, 1, active level of vn_in

Ports:
- clk_in  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- vn_in  in  1  vertical sync from the timing generator
- total_active_pix  in  X_BITS  active pixels per line
- cfg_pattern  in  8  manual pattern select
- cfg_auto  in  1  1 = auto-cycle, 0 = manual
- pattern  out  8  committed pattern code to the pattern stage
- ramp_step  out  B+FRACTIONAL_BITS  committed ramp increment
- busy  out  1  divider running or result not yet committed
- frame_start  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset==0 at a clk_in edge), all registered:
  - pattern=0, ramp_step=0, busy=0, frame_start=0.
  - Shadow step=0, latched_pix=0, frame counter=0, auto index=0, FSM=IDLE, pending=0.
  - vs_prev=VS_POL.
  - Reset mid-division aborts the divide; no partial result is kept.
- Frame boundary:
  - Occurs in the cycle where vn_in==VS_POL and vs_prev!=VS_POL.
  - frame_start is registered: it is high the cycle after that edge is sampled.
- Divider FSM, states IDLE, DIV, DONE:
  - IDLE: if total_active_pix != latched_pix, latch it, load remainder=0, numerator=2^(B+FRACTIONAL_BITS), go DIV, set busy.
  - DIV: restoring division, one quotient bit per cycle, MSB first. It runs exactly B+FRACTIONAL_BITS+1 cycles, then goes DONE.
  - DONE, one cycle:
    - shadow step = floor(2^(B+FRACTIONAL_BITS)/latched_pix), saturated to all-ones if the quotient exceeds B+FRACTIONAL_BITS bits or latched_pix==0.
    - Set pending; go IDLE.
  - total_active_pix changes during DIV: ignored until IDLE, which then sees the mismatch and restarts. Last value wins.
  - busy = (FSM!=IDLE) || pending.
- Commit at frame boundary. The boundary cycle updates outputs visible the next cycle:
  - Pattern:
    - Manual (cfg_auto=0): pattern <= cfg_pattern.
    - Auto: counter increments. At FRAMES_PER_PATTERN-1, counter<=0 and index advances, wrapping NUM_PATTERNS-1 -> 0. pattern <= index value after the update.
    - Switching cfg_auto 0->1 resumes from the stored index; the counter is not cleared.
  - ramp_step: if pending and FSM==IDLE, ramp_step <= shadow step and pending clears. If the FSM is in DIV or DONE at the boundary, ramp_step is held and committed at a later boundary.
  - Pattern commit is independent of divider state.
- Simultaneous events:
  - DONE in the same cycle as a boundary: step is not committed (FSM!=IDLE); it commits at the next boundary.
  - cfg_pattern changes outside a boundary never affect the pattern output.

Test Plan:
- Release reset, total_active_pix=1920, vn_in toggling every 2000 cycles -> busy high 22 cycles; first boundary after DONE gives ramp_step=0x00222 (546); pattern=cfg_pattern.
- total_active_pix=1280 -> ramp_step=0x00333 (819) at the next boundary after busy clears; unchanged before it.
- total_active_pix=1 and then 0 -> ramp_step=0xFFFFF (saturated) in both cases.
- cfg_auto=1, FRAMES_PER_PATTERN=2, NUM_PATTERNS=5 -> pattern sequence across boundaries 0,1,1,2,2,3,3,4,4,0; frame_start pulses once per frame.
- Change total_active_pix 1920->800 at DIV cycle 10 -> divide completes, restarts; final committed ramp_step=0x0051E (1310); no 546 commit if no boundary falls in between.
- Assert reset mid-DIV and release -> all outputs 0, busy re-asserts next cycle (latched_pix=0 mismatch), correct step committed later.
